// File: rtl/nios2_system_onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle shared by the two arbiter ports.
// The master modport drives commands; the slave modport answers with wait/response.
interface nios2_system_onchip_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_system_onchip_mem_arbiter.sv
// Two-master round-robin arbiter with bounded hold window in front of the
// single-port on-chip memory; routes 1-cycle read responses back to their owner.
module nios2_system_onchip_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 51200,
   parameter int HOLD   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reset_req,
   nios2_system_onchip_mem_arbiter_if.slave m0,
   nios2_system_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int CNT_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
   localparam int AW1   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [AW1-1:0]   DEPTH_C = AW1'(DEPTH);

   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;
   logic             rd_oor_q, rd_oor_d;

   logic              req0_s, req1_s, any_s, sel1_s, blk_s, acc_s, wr_s, in_range_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] rdata_s;

   // Grant selection, command mux and memory drive.
   always_comb begin
      req0_s = m0.read | m0.write;
      req1_s = m1.read | m1.write;
      any_s  = req0_s | req1_s;
      sel1_s = 1'b0;
      case ({req1_s, req0_s})
         2'b01:   sel1_s = 1'b0;
         2'b10:   sel1_s = 1'b1;
         // Contention: stay with the current owner until its window is used up.
         2'b11:   sel1_s = (cnt_q < HOLD_C) ? last_q : ~last_q;
         default: sel1_s = 1'b0;
      endcase
      blk_s = reset | reset_req;
      acc_s = any_s & ~blk_s;

      if (sel1_s) begin
         addr_s         = m1.address;
         wr_s           = m1.write;
         mem_byteenable = m1.byteenable;
         mem_writedata  = m1.writedata;
      end else begin
         addr_s         = m0.address;
         wr_s           = m0.write;
         mem_byteenable = m0.byteenable;
         mem_writedata  = m0.writedata;
      end
      in_range_s     = {1'b0, addr_s} < DEPTH_C;
      mem_address    = addr_s;
      mem_chipselect = acc_s & in_range_s;
      mem_write      = acc_s & wr_s & in_range_s;
      mem_clken      = 1'b1;

      m0.waitrequest = ~(any_s & ~sel1_s) | blk_s;
      m1.waitrequest = ~(any_s & sel1_s) | blk_s;
   end

   // Read response routing; an out-of-range read answers with zero.
   always_comb begin
      rdata_s          = rd_oor_q ? {DATA_W{1'b0}} : mem_readdata;
      m0.readdata      = rdata_s;
      m1.readdata      = rdata_s;
      m0.readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
      m1.readdatavalid = rd_pend_q & rd_owner_q & ~reset;
   end

   // Next-state for the round-robin history and the read pipeline.
   always_comb begin
      last_d     = last_q;
      cnt_d      = cnt_q;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;
      rd_oor_d   = rd_oor_q;
      if (acc_s) begin
         if (sel1_s == last_q) begin
            cnt_d = (cnt_q == HOLD_C) ? HOLD_C : cnt_q + ONE_C;
         end else begin
            last_d = sel1_s;
            cnt_d  = ONE_C;
         end
         rd_pend_d  = ~wr_s;
         rd_owner_d = sel1_s;
         rd_oor_d   = ~in_range_s;
      end else begin
         rd_pend_d = 1'b0;
      end
   end

   // State registers; reset makes m0 win the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= 1'b1;
         cnt_q      <= HOLD_C;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_oor_q   <= 1'b0;
      end else begin
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

endmodule

// File: tb/tb_nios2_system_onchip_mem_arbiter.sv
// Bench for the on-chip memory arbiter: behavioural grant/memory model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_nios2_system_onchip_mem_arbiter;
   localparam int AW = 16, DW = 32, DEPTH = 51200, HOLD = 2;

   logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0;
   always #5 clk = ~clk;

   nios2_system_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
   nios2_system_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata, mem_readdata;

   nios2_system_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .m0(m0), .m1(m1),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   logic [31:0] ram     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];

   // Memory stand-in: registered read of the pre-write contents, byte-lane writes.
   always @(posedge clk) begin
      if (mem_clken) begin
         mem_readdata <= (mem_address < DEPTH) ? ram[mem_address] : 32'h0;
         if (mem_chipselect && mem_write && mem_address < DEPTH)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end
   end

   int total = 0, bad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: history of granted masters; reset seeds it as a saturated m1 run.
   int   hist[$];
   bit   m_pend = 1'b0;
   int   m_owner = 0;
   logic [31:0] m_data = 32'h0;
   bit   chk_on = 1'b0;

   function automatic int pick(bit r0, bit r1);
      int lst, run;
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (!r0 && !r1) return -1;
      if (hist.size() == 0) return 0;
      lst = hist[hist.size()-1];
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == lst; i--) run++;
      return (run < HOLD) ? lst : 1 - lst;
   endfunction

   always @(negedge clk) begin : cmp
      int g;
      bit r0, r1, w, inr, pend_vis;
      logic [15:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      if (chk_on) begin
         r0 = m0.read | m0.write;
         r1 = m1.read | m1.write;
         g  = (reset || reset_req) ? -1 : pick(r0, r1);
         check("m0_waitrequest", {31'b0, m0.waitrequest}, {31'b0, g != 0});
         check("m1_waitrequest", {31'b0, m1.waitrequest}, {31'b0, g != 1});
         pend_vis = m_pend && !reset;
         check("m0_readdatavalid", {31'b0, m0.readdatavalid}, {31'b0, pend_vis && m_owner == 0});
         check("m1_readdatavalid", {31'b0, m1.readdatavalid}, {31'b0, pend_vis && m_owner == 1});
         if (pend_vis) begin
            check("m0_readdata", m0.readdata, m_data);
            check("m1_readdata", m1.readdata, m_data);
         end
         a   = (g == 1) ? m1.address : m0.address;
         w   = (g == 1) ? m1.write : m0.write;
         wd  = (g == 1) ? m1.writedata : m0.writedata;
         be  = (g == 1) ? m1.byteenable : m0.byteenable;
         inr = (a < DEPTH);
         check("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, g >= 0 && inr});
         check("mem_write", {31'b0, mem_write}, {31'b0, g >= 0 && w && inr});
         check("mem_clken", {31'b0, mem_clken}, 32'h1);
         if (g >= 0 && inr) begin
            check("mem_address", {16'b0, mem_address}, {16'b0, a});
            if (w) begin
               check("mem_writedata", mem_writedata, wd);
               check("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, be});
            end
         end
         if (reset) begin
            hist.delete();
            for (int i = 0; i < HOLD; i++) hist.push_back(1);
            m_pend = 1'b0;
         end else begin
            m_pend = 1'b0;
            if (g >= 0) begin
               hist.push_back(g);
               if (!w) begin
                  m_pend  = 1'b1;
                  m_owner = g;
                  m_data  = inr ? ref_mem[a] : 32'h0;
               end else if (inr) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0.read = 1'b0; m0.write = 1'b0;
      m1.read = 1'b0; m1.write = 1'b0;
   endtask

   int gseq;
   int exp2[6] = '{0, 0, 1, 1, 0, 0};

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = (32'(i) * 32'h00010003) ^ 32'h5A5A0000;
         ref_mem[i] = (32'(i) * 32'h00010003) ^ 32'h5A5A0000;
      end
      ram[16] = 32'h12345678;  ref_mem[16] = 32'h12345678;
      ram[256] = 32'hFFFFFFFF; ref_mem[256] = 32'hFFFFFFFF;
      idle();
      m0.address = 16'h0; m1.address = 16'h0;
      m0.writedata = 32'h0; m1.writedata = 32'h0;
      m0.byteenable = 4'hF; m1.byteenable = 4'hF;
      cyc();
      chk_on = 1'b1;
      @(negedge clk);
      check("rst_wait0", {31'b0, m0.waitrequest}, 32'h1);
      check("rst_wait1", {31'b0, m1.waitrequest}, 32'h1);
      check("rst_cs", {31'b0, mem_chipselect}, 32'h0);
      cyc();
      reset = 1'b0;

      // Single read from m0.
      m0.address = 16'h0010; m0.read = 1'b1;
      @(negedge clk); check("t1_wait0", {31'b0, m0.waitrequest}, 32'h0);
      cyc(); m0.read = 1'b0;
      @(negedge clk);
      check("t1_rdv0", {31'b0, m0.readdatavalid}, 32'h1);
      check("t1_data", m0.readdata, 32'h12345678);
      check("t1_rdv1", {31'b0, m1.readdatavalid}, 32'h0);
      cyc();

      // Contention from reset with HOLD=2.
      reset = 1'b1; cyc(); reset = 1'b0;
      m0.address = 16'h0020; m1.address = 16'h0030;
      m0.read = 1'b1; m1.read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         gseq = !m0.waitrequest ? 0 : (!m1.waitrequest ? 1 : 3);
         check($sformatf("t2_grant%0d", k), 32'(gseq), 32'(exp2[k]));
         cyc();
      end
      idle(); cyc();

      // Partial write by m1 then readback by m0.
      m1.address = 16'h0100; m1.writedata = 32'hA5A5A5A5; m1.byteenable = 4'b0011; m1.write = 1'b1;
      @(negedge clk); check("t3_wait1", {31'b0, m1.waitrequest}, 32'h0);
      cyc(); m1.write = 1'b0; m0.address = 16'h0100; m0.read = 1'b1;
      cyc(); m0.read = 1'b0;
      @(negedge clk);
      check("t3_rdv0", {31'b0, m0.readdatavalid}, 32'h1);
      check("t3_data", m0.readdata, 32'hFFFFA5A5);
      cyc();

      // Out-of-range write and read.
      m0.address = 16'hC800; m0.writedata = 32'hDEADBEEF; m0.byteenable = 4'hF; m0.write = 1'b1;
      @(negedge clk);
      check("t4_wwait", {31'b0, m0.waitrequest}, 32'h0);
      check("t4_cs", {31'b0, mem_chipselect}, 32'h0);
      cyc(); m0.write = 1'b0; m0.read = 1'b1;
      @(negedge clk); check("t4_rwait", {31'b0, m0.waitrequest}, 32'h0);
      cyc(); m0.read = 1'b0;
      @(negedge clk);
      check("t4_rdv", {31'b0, m0.readdatavalid}, 32'h1);
      check("t4_data", m0.readdata, 32'h00000000);
      cyc();

      // reset_req blocks both masters for 3 cycles.
      m0.address = 16'h0040; m1.address = 16'h0050; m0.read = 1'b1; m1.read = 1'b1;
      reset_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t5_wait0_%0d", k), {31'b0, m0.waitrequest}, 32'h1);
         check($sformatf("t5_wait1_%0d", k), {31'b0, m1.waitrequest}, 32'h1);
         check($sformatf("t5_cs_%0d", k), {31'b0, mem_chipselect}, 32'h0);
         cyc();
      end
      reset_req = 1'b0;
      @(negedge clk);
      check("t5_resume_cs", {31'b0, mem_chipselect}, 32'h1);
      check("t5_resume_one", {31'b0, m0.waitrequest ^ m1.waitrequest}, 32'h1);
      cyc(); idle(); cyc();

      // Reset drops an outstanding read; m0 wins first contention afterwards.
      m0.address = 16'h0010; m0.read = 1'b1;
      @(negedge clk); check("t6_wait0", {31'b0, m0.waitrequest}, 32'h0);
      cyc(); m0.read = 1'b0; reset = 1'b1;
      @(negedge clk); check("t6_rdv0", {31'b0, m0.readdatavalid}, 32'h0);
      cyc(); reset = 1'b0;
      m0.read = 1'b1; m1.read = 1'b1; m1.address = 16'h0060;
      @(negedge clk);
      check("t6_g0_wait0", {31'b0, m0.waitrequest}, 32'h0);
      check("t6_g0_wait1", {31'b0, m1.waitrequest}, 32'h1);
      cyc(); idle(); cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nios2_system_onchip_mem_arbiter.md
# nios2_system_onchip_mem_arbiter

Two-master arbiter that shares the single-port on-chip memory (`nios2_system_onchip_mem`, 51200 × 32-bit words, 1-cycle read latency) between the Nios II data master and a second Avalon-MM master such as a DMA engine. It selects one command per cycle using round-robin with a bounded hold window. It drives the memory's Avalon slave port and routes read responses back to the master that issued the read. It also blocks accesses beyond the memory depth and stalls new commands while `reset_req` is asserted.

## Interface
- `ADDR_W`, 16, word-address width on all ports
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `DEPTH`, 51200, number of valid words; addresses ≥ `DEPTH` are out of range
- `HOLD`, 4, maximum consecutive grants to one master while the other is requesting (≥1; 1 = strict round-robin)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `reset_req`  in  1  memory reset request; blocks new grants
- `mN_address`  in  ADDR_W  word address (N = 0, 1)
- `mN_byteenable`  in  DATA_W/8  write byte lanes
- `mN_read`  in  1  read request
- `mN_write`  in  1  write request
- `mN_writedata`  in  DATA_W  write data
- `mN_waitrequest`  out  1  high = command not accepted this cycle
- `mN_readdata`  out  DATA_W  read data
- `mN_readdatavalid`  out  1  high for one cycle when `mN_readdata` is valid
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_byteenable`  out  DATA_W/8  to memory `byteenable`
- `mem_chipselect`  out  1  to memory `chipselect`
- `mem_write`  out  1  to memory `write`
- `mem_writedata`  out  DATA_W  to memory `writedata`
- `mem_clken`  out  1  to memory `clken`; tied to 1
- `mem_readdata`  in  DATA_W  from memory `readdata`, valid the cycle after a read is issued

## Operation
- Request: `reqN = mN_read | mN_write`. If `read` and `write` are both high, the command is treated as a write.
- Acceptance: grant is combinational in the current cycle.
  - `mN_waitrequest = ~grantN | reset | reset_req`.
  - A command is accepted when `reqN & ~mN_waitrequest`.
  - A master must hold its command stable while waitrequest is high.
- State registers:
  - `last`: 1 bit, the master granted most recently.
  - `cnt`: 0..HOLD, consecutive grants to `last`.
  - Read pipeline: `rd_pend`, `rd_owner`, `rd_oor`.
- Grant rule:
  - Only one master requesting → grant it.
  - Both requesting, `cnt < HOLD` → grant `last`.
  - Both requesting, `cnt == HOLD` → grant `~last`.
- Update on an accepted command:
  - Granted master equals `last` → `cnt = min(cnt+1, HOLD)`.
  - Otherwise → `last` = granted master, `cnt = 1`.
  - `last` and `cnt` do not change in idle cycles.
- Memory drive: with no accepted command, `mem_chipselect = 0` and `mem_write = 0`. The address and data muxes follow the granted master (m0 when neither is granted).
  - `mem_write = accepted write & in-range`.
  - `mem_chipselect` = accepted & in-range.
- Out-of-range (`address ≥ DEPTH`): the command is still accepted.
  - Write: suppressed, memory is not touched.
  - Read: the response is returned with data 0.
- Read response: an accepted read sets `rd_pend = 1`, `rd_owner = N`, `rd_oor`.
  - Next cycle, `m<rd_owner>_readdatavalid = 1`.
  - `readdata = rd_oor ? 0 : mem_readdata`.
  - Both `mN_readdata` outputs carry the same value. Only the owner's valid bit is asserted.
- Back-to-back reads are supported: one response per cycle, in order.
- `reset_req`: no grants are given. A response already pending is still delivered the next cycle.
- Reset: `last = 1` and `cnt = HOLD`, so m0 wins the first contention. `rd_pend = 0`.

## Timing
- Output values while `reset` is high: both waitrequests 1, both readdatavalids 0, `mem_chipselect` 0, `mem_write` 0, `mem_clken` 1.
- Read latency: command accepted in cycle T → `readdatavalid` in cycle T+1.
- Write completes in the acceptance cycle, with no response.
- Throughput: one accepted command per cycle with no bubbles, including when grant switches between masters.
- Reset asserted while a read is outstanding: the response is dropped and `readdatavalid` stays 0.
- Read-during-write to the same address from the other master is resolved by order: the command granted first takes effect first. A read in the cycle after a write returns the new data.

## Test plan
- Single master m0 reads address 0x0010 (preloaded with 0x12345678), m1 idle → waitrequest 0 in cycle T, `m0_readdatavalid = 1` with 0x12345678 at T+1, `m1_readdatavalid` stays 0.
- Both masters issue continuous reads, `HOLD = 2`, from reset → grant sequence m0, m0, m1, m1, m0, m0. Each response goes to the correct owner, one per cycle.
- m1 writes 0xA5A5A5A5 to 0x0100 with byteenable 0b0011 over preload 0xFFFFFFFF, then m0 reads 0x0100 the next cycle → m0 receives 0xFFFFA5A5.
- m0 writes 0xDEADBEEF to address 51200, then reads 51200 → write accepted with `mem_chipselect = 0`; the read returns 0x00000000 with readdatavalid.
- `reset_req` is held for 3 cycles while both masters request → both waitrequests are 1 and `mem_chipselect = 0` for those cycles. Grant resumes the cycle after deassertion.
- m0 read is accepted in cycle T and `reset` is asserted in T+1 → no `m0_readdatavalid`. After reset, the first contention grants m0.
